// File: rtl/pixel_program_sequencer.sv
// Issues program-memory opcodes to the core array one per clock and packs the
// returned output_bit stream into pixels for a valid/ready pixel sink.
module pixel_program_sequencer #(
  parameter int PROG_ADDR_WIDTH = 8,
  parameter int PIXEL_BITS      = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       prog_en,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]                prog_data,
  output logic [15:0]                opcode,
  output logic                       execute,
  input  logic                       output_bit,
  output logic [PIXEL_BITS-1:0]      pixel_data,
  output logic                       pixel_valid,
  input  logic                       pixel_ready
);

  localparam int CW = $clog2(PIXEL_BITS + 1);
  localparam logic [CW-1:0]              LAST_CNT = CW'(PIXEL_BITS - 1);
  localparam logic [CW-1:0]              CNT_ONE  = CW'(1);
  localparam logic [CW+1:0]              LAST_SUM = (CW + 2)'(PIXEL_BITS - 1);
  localparam logic [PROG_ADDR_WIDTH-1:0] PC_ONE   = PROG_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                     state_r, state_s;
  logic [PROG_ADDR_WIDTH-1:0] pc_r, pc_s;
  logic                       drain_cnt_r, drain_cnt_s;
  logic                       busy_s, done_s, execute_s, pend0_s;
  logic [15:0]                opcode_s;
  logic                       pend0_r, pend1_r;
  logic [CW-1:0]              count_r;
  logic [PIXEL_BITS-2:0]      shift_r;
  logic [PIXEL_BITS-1:0]      shift_s;
  logic [CW+1:0]              inflight_s;
  logic                       is_halt_s, is_cap_s, stall_s, complete_s, start_ok_s;

  function automatic logic is_capture(input logic [15:0] op);
    return (op[15:14] == 2'b11) && op[4];
  endfunction

  function automatic logic is_halt(input logic [15:0] op);
    return (op[15:14] == 2'b11) && (op[3:0] == 4'hF);
  endfunction

  assign prog_addr  = pc_r;
  assign is_halt_s  = is_halt(prog_data);
  assign is_cap_s   = is_capture(prog_data);
  assign inflight_s = {2'b00, count_r} + {{(CW + 1){1'b0}}, pend0_r} + {{(CW + 1){1'b0}}, pend1_r};
  // Hold a pixel-completing capture while the output buffer is still occupied.
  assign stall_s    = is_cap_s && (inflight_s == LAST_SUM) && pixel_valid && !pixel_ready;
  assign complete_s = pend1_r && (count_r == LAST_CNT);
  assign start_ok_s = (state_r == IDLE) && start;
  assign shift_s    = {shift_r, output_bit};

  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    drain_cnt_s = drain_cnt_r;
    busy_s      = busy;
    done_s      = 1'b0;
    execute_s   = 1'b0;
    opcode_s    = opcode;
    pend0_s     = 1'b0;
    prog_en     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = FETCH;
          busy_s  = 1'b1;
          pc_s    = {PROG_ADDR_WIDTH{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        prog_en = 1'b1;
        pc_s    = PC_ONE;
        state_s = RUN;
      end
      RUN: begin
        if (is_halt_s) begin
          state_s     = DRAIN;
          drain_cnt_s = 1'b0;
        end else if (stall_s) begin
          state_s = RUN;
        end else begin
          prog_en   = 1'b1;
          opcode_s  = prog_data;
          execute_s = 1'b1;
          pc_s      = pc_r + PC_ONE;
          pend0_s   = is_cap_s;
        end
      end
      DRAIN: begin
        if (drain_cnt_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          drain_cnt_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= {PROG_ADDR_WIDTH{1'b0}};
      drain_cnt_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      opcode      <= 16'h0000;
      execute     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      drain_cnt_r <= drain_cnt_s;
      busy        <= busy_s;
      done        <= done_s;
      opcode      <= opcode_s;
      execute     <= execute_s;
    end
  end

  // Capture pipeline: output_bit lands two edges after its capture opcode issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend0_r     <= 1'b0;
      pend1_r     <= 1'b0;
      count_r     <= {CW{1'b0}};
      shift_r     <= {(PIXEL_BITS - 1){1'b0}};
      pixel_data  <= {PIXEL_BITS{1'b0}};
      pixel_valid <= 1'b0;
    end else begin
      pend0_r <= pend0_s;
      pend1_r <= pend0_r;
      if (pend1_r) shift_r <= shift_s[PIXEL_BITS-2:0];
      else         shift_r <= shift_r;
      if (start_ok_s || complete_s) count_r <= {CW{1'b0}};
      else if (pend1_r)             count_r <= count_r + CNT_ONE;
      else                          count_r <= count_r;
      if (complete_s) begin
        pixel_data  <= shift_s;
        pixel_valid <= 1'b1;
      end else if (pixel_ready) begin
        pixel_valid <= 1'b0;
      end else begin
        pixel_valid <= pixel_valid;
      end
    end
  end

endmodule
